// File: rtl/llr_ram_loader.sv
// llr_ram_loader
//   Accepts one codeword of channel LLRs from a valid/ready stream and writes
//   it to a single-port sync-read RAM at ascending addresses. On request, it
//   streams the stored codeword back out in address order to the decoder core.
//   This block owns every RAM strobe.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   flush          synchronous abort that discards the codeword and returns to IDLE
//   in_valid/in_ready/in_data     input LLR stream (valid/ready handshake)
//   rd_start       one-cycle pulse that starts readout; acted on only when FULL
//   out_valid/out_data/out_last   output LLR stream, no backpressure
//   loaded         a complete codeword is stored and has not been read out
//   word_count     number of beats stored so far (0..CW_LEN)
//   ram_cs, ram_we, ram_address, ram_data_in, ram_data_out   RAM port
module llr_ram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int CW_LEN     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  rd_start,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  loaded,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // The codeword length can never exceed the RAM, so it is clamped to DEPTH.
  localparam int LEN = (CW_LEN > DEPTH) ? DEPTH : CW_LEN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FULL  = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  accept;
  logic                  rd_issue;

  // flush blocks both the write handshake and any read issue in its cycle.
  assign in_ready = ((state == IDLE) || (state == LOAD)) && !flush;
  assign accept   = in_valid && in_ready;
  assign rd_issue = (state == READ) && !flush;

  assign ram_cs      = accept || rd_issue;
  assign ram_we      = accept;
  assign ram_address = (state == READ) ? rd_ptr : wr_ptr;
  assign ram_data_in = in_data;

  // The RAM already registers its output, so the data passes straight through
  // and lines up with the registered out_valid.
  assign out_data = ram_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      loaded     <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      loaded     <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (accept) begin
            word_count <= word_count + (ADDR_WIDTH + 1)'(1);
            // wr_ptr stays on the last address so that it never wraps.
            if (wr_ptr == LAST_ADDR) begin
              state  <= FULL;
              loaded <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
              state  <= LOAD;
            end
          end
        end
        FULL: begin
          if (rd_start) begin
            state  <= READ;
            rd_ptr <= '0;
          end
        end
        READ: begin
          out_valid <= 1'b1;
          if (rd_ptr == LAST_ADDR) begin
            out_last <= 1'b1;
            state    <= DRAIN;
          end else begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // The final word is on out_data during this cycle.
          state      <= IDLE;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          word_count <= '0;
          loaded     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llr_ram_loader.sv
module tb_llr_ram_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       rd_start = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       loaded;
  logic [8:0] word_count;
  logic       ram_cs;
  logic       ram_we;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] mem [0:255];

  llr_ram_loader #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .CW_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_start(rd_start),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .loaded(loaded), .word_count(word_count),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port sync-read RAM
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_address] <= ram_data_in;
      else        ram_data_out     <= mem[ram_address];
    end
  end

  // Strobe log, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && ram_cs && ram_we) begin
      wa.push_back(ram_address);
      wd.push_back(ram_data_in);
    end
    if (!rst && ram_cs && !ram_we) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic load4(input logic [31:0] ev);
    for (int i = 0; i < 4; i++) load_beat(ev[31-8*i -: 8]);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] ev);
    chk({tag, "_nwr"}, wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk({tag, "_waddr"}, wa[i], i);
      chk({tag, "_wdata"}, wd[i], ev[31-8*i -: 8]);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] ev);
    int r0;
    r0 = rd_cnt;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    @(negedge clk);
    chk({tag, "_lat_vld"}, out_valid, 0);
    chk({tag, "_rd_cs"}, ram_cs, 1);
    chk({tag, "_rd_we"}, ram_we, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_vld"}, out_valid, 1);
      chk({tag, "_data"}, out_data, ev[31-8*i -: 8]);
      chk({tag, "_last"}, out_last, (i == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk({tag, "_end_vld"}, out_valid, 0);
    chk({tag, "_end_loaded"}, loaded, 0);
    chk({tag, "_end_ready"}, in_ready, 1);
    chk({tag, "_end_cnt"}, word_count, 0);
    chk({tag, "_nrd"}, rd_cnt - r0, 4);
    step();
  endtask

  initial begin
    int r0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_cnt", word_count, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_ready", in_ready, 1);
    step();

    // Back-to-back fill then readout
    wa.delete(); wd.delete();
    load4(32'h11223344);
    @(negedge clk);
    chk("fill_loaded", loaded, 1);
    chk("fill_ready", in_ready, 0);
    chk("fill_cnt", word_count, 4);
    chk("fill_cs", ram_cs, 0);
    check_writes("fill", 32'h11223344);
    step();
    do_read("rd1", 32'h11223344);

    // Load with gaps: 1 valid, 2 idle
    wa.delete(); wd.delete();
    for (int i = 0; i < 4; i++) begin
      load_beat(8'h55 + 8'(17 * i));
      @(negedge clk);
      chk("gap_cnt", word_count, i + 1);
      chk("gap_idle_we", ram_we, 0);
      step();
      step();
    end
    chk("gap_loaded", loaded, 1);
    check_writes("gap", 32'h55667788);
    do_read("rd2", 32'h55667788);

    // flush together with the 3rd beat
    wa.delete(); wd.delete();
    load_beat(8'hA1);
    load_beat(8'hA2);
    in_valid = 1'b1; in_data = 8'hA3; flush = 1'b1;
    @(negedge clk);
    chk("fl_we", ram_we, 0);
    chk("fl_ready", in_ready, 0);
    step();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl_cnt", word_count, 0);
    chk("fl_ready_after", in_ready, 1);
    chk("fl_nwr", wa.size(), 2);
    step();
    wa.delete(); wd.delete();
    load4(32'hB1B2B3B4);
    check_writes("reload", 32'hB1B2B3B4);
    do_read("rd3", 32'hB1B2B3B4);

    // rd_start in IDLE and in LOAD is ignored
    r0 = rd_cnt;
    rd_start = 1'b1; step(); rd_start = 1'b0;
    @(negedge clk);
    chk("ign_idle_vld", out_valid, 0);
    chk("ign_idle_cnt", word_count, 0);
    step();
    wa.delete(); wd.delete();
    load_beat(8'hC1);
    load_beat(8'hC2);
    rd_start = 1'b1; step(); rd_start = 1'b0;
    @(negedge clk);
    chk("ign_load_vld", out_valid, 0);
    chk("ign_load_cnt", word_count, 2);
    chk("ign_load_ready", in_ready, 1);
    chk("ign_nrd", rd_cnt - r0, 0);
    step();
    load_beat(8'hC3);
    load_beat(8'hC4);
    check_writes("ign", 32'hC1C2C3C4);
    chk("ign_loaded", loaded, 1);
    do_read("rd4", 32'hC1C2C3C4);

    // Async reset during READ after 2 outputs
    load4(32'hD1D2D3D4);
    rd_start = 1'b1; step(); rd_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_d0", out_data, 8'hD1);
    @(negedge clk);
    chk("ar_d1", out_data, 8'hD2);
    chk("ar_vld_pre", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_cs", ram_cs, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ar_ready", in_ready, 1);
    chk("ar_cnt", word_count, 0);
    chk("ar_loaded", loaded, 0);
    chk("ar_vld_after", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
